serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 The block SHALL have port a  input  WIDTH  operand A; captured at accept.
REQ-006 The block SHALL have port b  input  WIDTH  operand B; captured at accept.
REQ-007 The block SHALL have port cin  input  1  carry-in; captured at accept.
REQ-008 The block SHALL have port busy  output  1  high while the addition is in progress (state RUN).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse marking that sum/cout hold a new result (state DONE).
REQ-010 The block SHALL have port sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-011 The block SHALL have port cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; all outputs registered or decoded from state only.
REQ-013 In IDLE with start=1 at a rising edge (accept edge E0), the block SHALL load a, b into internal shift registers, load cin into the carry flop, clear the bit counter, and enter RUN.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE with all registers holding.
REQ-015 In RUN, each rising edge SHALL process exactly one bit, LSB first, using a single 1-bit full-adder datapath: s = a0 ^ b0 ^ c; c_next = (a0 & b0) | (c & (a0 ^ b0)).
REQ-016 Each RUN edge SHALL shift the operand registers right by one, shift s into the MSB of the internal result shift register, update the carry flop, and increment the bit counter.
REQ-017 On the RUN edge that processes bit WIDTH-1 (edge E0+WIDTH), the block SHALL load sum with the complete result, load cout with c_next, and enter DONE.
REQ-018 busy SHALL be 1 exactly in the WIDTH cycles following edges E0 .. E0+WIDTH-1, and 0 otherwise.
REQ-019 done SHALL be 1 for exactly one cycle, the cycle following edge E0+WIDTH, and 0 otherwise.
REQ-020 From DONE the block SHALL return to IDLE unconditionally on the next edge; the minimum start-to-start period is WIDTH+2 cycles.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing; a request held high is accepted at the first IDLE edge.
REQ-022 Changes on a, b, cin after E0 SHALL NOT affect the result in progress.
REQ-023 sum and cout SHALL change only at the RUN-to-DONE edge and hold their values until the next completion or reset; partial results SHALL NOT appear on sum.
REQ-024 The bit counter SHALL be sized ceil(log2(WIDTH))+1 bits and SHALL NOT wrap within an operation.

Reset
REQ-025 While rst=1, asynchronously and independent of clk: state=IDLE, busy=0, done=0, sum=0, cout=0, and the shift registers, carry flop and counter are cleared.
REQ-026 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first accept SHALL be possible at the first rising edge after rst deasserts.

Verification
REQ-027 WIDTH=8, a=8'h0F, b=8'h01, cin=0, start pulse -> done only in the cycle after E0+8, busy high 8 cycles, sum=8'h10, cout=0.
REQ-028 a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-029 start held high continuously with fixed a=8'h03, b=8'h05 -> done pulses every 10 cycles, each with sum=8'h08, cout=0.
REQ-030 a and b changed to random values on every cycle of RUN -> result equals the values captured at E0.
REQ-031 rst asserted during the 4th RUN cycle -> busy, done, sum, cout go 0 immediately, with no done pulse afterwards; a new start after release completes correctly.
REQ-032 1000 random a, b, cin at WIDTH=8 and WIDTH=32 -> {cout,sum} equals a+b+cin on every done pulse, and the previous result is held between pulses.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with start/busy/done handshake: one full-adder step per clock, LSB first.
// The full result appears on sum/cout only when the last bit has been processed.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    assign s        = a_sr[0] ^ b_sr[0] ^ carry;
    assign c_next   = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 has reached the LSB.
    assign res_next = {s, res_sr[WIDTH-1:1]};

    // NOTE: every register here is state, so all assignments are non-blocking and
    // each one is cleared by the asynchronous reset, including the shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        carry   <= cin;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    res_sr  <= res_next;
                    carry   <= c_next;
                    bit_cnt <= bit_cnt + CW'(1);
                    if (bit_cnt == LAST_BIT) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: an 8-bit and a 32-bit instance share clock and reset;
// expected {cout,sum} values are queued at request time and popped on each done pulse.
module tb_serial_adder_ctrl;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start32, cin32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0]  q8[$];
    logic [32:0] q32[$];
    logic [8:0]  last8, e8;
    logic [32:0] last32, e32;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    // Result monitor: checks every done pulse against the queue and that results hold in between.
    always @(negedge clk) begin
        if (rst) begin
            last8  = '0;
            last32 = '0;
        end else begin
            vectors++;
            if (done8) begin
                if (q8.size() == 0) begin
                    miscompares++;
                    $display("FAIL done8_unexpected: done pulse with nothing pending, sum=%h cout=%b", sum8, cout8);
                end else begin
                    e8 = q8.pop_front();
                    if ({cout8, sum8} !== e8) begin
                        miscompares++;
                        $display("FAIL result8: got %h, expected %h", {cout8, sum8}, e8);
                    end
                    last8 = e8;
                end
            end else if ({cout8, sum8} !== last8) begin
                miscompares++;
                $display("FAIL hold8: got %h, expected %h", {cout8, sum8}, last8);
            end
            vectors++;
            if (done32) begin
                if (q32.size() == 0) begin
                    miscompares++;
                    $display("FAIL done32_unexpected: done pulse with nothing pending, sum=%h cout=%b", sum32, cout32);
                end else begin
                    e32 = q32.pop_front();
                    if ({cout32, sum32} !== e32) begin
                        miscompares++;
                        $display("FAIL result32: got %h, expected %h", {cout32, sum32}, e32);
                    end
                    last32 = e32;
                end
            end else if ({cout32, sum32} !== last32) begin
                miscompares++;
                $display("FAIL hold32: got %h, expected %h", {cout32, sum32}, last32);
            end
        end
    end

    task automatic wait_idle(input bit wide);
        int t = 0;
        while ((wide ? (busy32 | done32) : (busy8 | done8)) !== 1'b0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: width=%0d still busy/done after %0d cycles", wide ? 32 : 8, t);
        end
    endtask

    task automatic run_op(input bit wide, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input int gap);
        int t = 0;
        logic bsy, dn;
        repeat (gap) @(negedge clk);
        wait_idle(wide);
        if (wide) begin
            a32 = a; b32 = b; cin32 = c; start32 = 1'b1;
            q32.push_back({1'b0, a} + {1'b0, b} + 33'(c));
        end else begin
            a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = 1'b1;
            q8.push_back({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(c));
        end
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        bsy = wide ? busy32 : busy8;
        vectors++;
        if (bsy !== 1'b1) begin
            miscompares++;
            $display("FAIL accept: width=%0d busy=%b after start, expected 1", wide ? 32 : 8, bsy);
        end
        dn = wide ? done32 : done8;
        while (dn !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
            dn = wide ? done32 : done8;
        end
        if (dn !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: width=%0d no done within %0d cycles", wide ? 32 : 8, t);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start32 = 1'b0; a32 = '0; b32 = '0; cin32 = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0 || {busy32, done32, cout32, sum32} !== 35'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %b/%h, expected all zero",
                     {busy8, done8, cout8, sum8}, {busy32, done32, cout32, sum32});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic eb, ed;
        wait_idle(0);
        a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h010);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start8 = 1'b0;
            eb = (k <= 8);
            ed = (k == 9);
            vectors++;
            if (busy8 !== eb || done8 !== ed) begin
                miscompares++;
                $display("FAIL basic_timing: cycle %0d busy=%b done=%b, expected busy=%b done=%b",
                         k, busy8, done8, eb, ed);
            end
        end
        run_op(0, 32'hFF, 32'h01, 1'b0, 0);
        run_op(0, 32'hFF, 32'hFF, 1'b1, 1);
        run_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
        run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        logic eb, ed;
        wait_idle(0);
        for (int i = 0; i < 4; i++) q8.push_back(9'h008);
        a8 = 8'h03; b8 = 8'h05; cin8 = 1'b0; start8 = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            @(negedge clk);
            if (k == 31) start8 = 1'b0;
            eb = (k % 10 >= 1) && (k % 10 <= 8) && (k <= 38);
            ed = (k % 10 == 9) && (k <= 39);
            vectors++;
            if (busy8 !== eb || done8 !== ed) begin
                miscompares++;
                $display("FAIL back_to_back: cycle %0d busy=%b done=%b, expected busy=%b done=%b",
                         k, busy8, done8, eb, ed);
            end
        end
    endtask

    task automatic test_operand_change();
        wait_idle(0);
        a8 = 8'h5A; b8 = 8'hC3; cin8 = 1'b1; start8 = 1'b1;
        q8.push_back(9'h11E);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'($urandom_range(0, 1));
            start8 = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start8 = 1'b0;
        vectors++;
        if (done8 !== 1'b1) begin
            miscompares++;
            $display("FAIL operand_change_done: done=%b, expected 1", done8);
        end
    endtask

    task automatic test_mid_run_reset();
        wait_idle(0);
        a8 = 8'hA5; b8 = 8'h3C; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: busy/done/cout/sum=%b, expected all zero", {busy8, done8, cout8, sum8});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
        q8.push_back(9'h046);
        @(negedge clk);
        start8 = 1'b0;
        vectors++;
        if (busy8 !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_accept: busy=%b, expected 1", busy8);
        end
        wait_idle(0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++)
            run_op(0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        for (int i = 0; i < 1000; i++)
            run_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        repeat (3) @(negedge clk);
        vectors++;
        if (q8.size() != 0 || q32.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d results still pending, expected 0/0", q8.size(), q32.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_operand_change();
        test_mid_run_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
